// File: rtl/pixel_pkg.sv
// pixel_pkg: definitions shared by the colour engines, the pixel distributor
// and the reorder/merge block.
//   PIX_COORD_W / PIX_RGB_W : default coordinate and colour widths
//   PIX_X_SIZE / PIX_Y_SIZE : default frame geometry
//   pixel_t                 : one finished pixel as produced by an engine
package pixel_pkg;

    localparam int PIX_COORD_W = 11;
    localparam int PIX_RGB_W   = 24;
    localparam int PIX_X_SIZE  = 640;
    localparam int PIX_Y_SIZE  = 480;

    typedef struct packed {
        logic [PIX_COORD_W-1:0] x;
        logic [PIX_COORD_W-1:0] y;
        logic [PIX_RGB_W-1:0]   colour;
    } pixel_t;

endpackage

// File: rtl/coord_fifo.sv
// coord_fifo: one channel's circular buffer of finished pixels.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push/wdata : write request; ignored while full
//   pop        : remove the head entry; ignored while empty
//   head       : entry at the read pointer (registered storage)
//   full/empty : derived from the registered occupancy count
module coord_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 46
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    always_comb begin
        full     = (count_q == DEPTH_C);
        empty    = (count_q == '0);
        // Acceptance looks only at the registered count, so a push into a
        // full channel is refused even when that channel pops this cycle.
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign head = mem[rd_ptr_q];

endmodule

// File: rtl/pixel_reorder_merge.sv
// pixel_reorder_merge: merges out-of-order pixels from NUM_CH colour engines
// into a raster-ordered valid/ready stream.
//   in_valid/in_x/in_y/in_colour : per-channel push (packed, channel 0 in LSBs)
//   in_ready, ch_full            : per-channel space / full status
//   out_valid/out_ready          : output handshake
//   out_colour/out_sof/out_eol   : registered output pixel and markers
//   frame_done                   : pulse after the last pixel of a frame is taken
//   stall_err                    : sticky deadlock indication
module pixel_reorder_merge
    import pixel_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 8,
    parameter int COORD_W = PIX_COORD_W,
    parameter int RGB_W   = PIX_RGB_W,
    parameter int X_SIZE  = PIX_X_SIZE,
    parameter int Y_SIZE  = PIX_Y_SIZE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*COORD_W-1:0] in_x,
    input  logic [NUM_CH*COORD_W-1:0] in_y,
    input  logic [NUM_CH*RGB_W-1:0]   in_colour,
    output logic [NUM_CH-1:0]         ch_full,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RGB_W-1:0]          out_colour,
    output logic                      out_sof,
    output logic                      out_eol,
    output logic                      frame_done,
    output logic                      stall_err
);

    localparam int                 PIX_W  = 2*COORD_W + RGB_W;
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(X_SIZE-1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(Y_SIZE-1);

    logic [PIX_W-1:0]   head [NUM_CH];
    logic [NUM_CH-1:0]  full, empty, match, pop_vec;
    logic [RGB_W-1:0]   sel_col;
    logic               found, pop_en;

    logic [COORD_W-1:0] exp_x_q, exp_x_d, exp_y_q, exp_y_d;
    logic               out_valid_q, out_valid_d;
    logic [RGB_W-1:0]   out_colour_q, out_colour_d;
    logic               out_sof_q, out_sof_d;
    logic               out_eol_q, out_eol_d;
    // Remembers that the pixel in the output register sits on the last line.
    logic               out_last_q, out_last_d;
    logic               frame_done_q, frame_done_d;
    logic               stall_err_q, stall_err_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        coord_fifo #(
            .DEPTH (DEPTH),
            .W     (PIX_W)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (in_valid[c]),
            .pop   (pop_vec[c]),
            .wdata ({in_x[c*COORD_W +: COORD_W],
                     in_y[c*COORD_W +: COORD_W],
                     in_colour[c*RGB_W +: RGB_W]}),
            .head  (head[c]),
            .full  (full[c]),
            .empty (empty[c])
        );
    end

    assign in_ready = ~full;
    assign ch_full  = full;

    always_comb begin
        match   = '0;
        pop_vec = '0;
        sel_col = '0;
        found   = 1'b0;

        for (int c = 0; c < NUM_CH; c++) begin
            match[c] = !empty[c]
                       && (head[c][PIX_W-1 -: COORD_W] == exp_x_q)
                       && (head[c][RGB_W +: COORD_W]   == exp_y_q);
        end

        pop_en = (|match) && (!out_valid_q || out_ready);

        // Fixed priority: the lowest-index matching channel is popped.
        for (int c = 0; c < NUM_CH; c++) begin
            if (pop_en && match[c] && !found) begin
                found      = 1'b1;
                pop_vec[c] = 1'b1;
                sel_col    = head[c][RGB_W-1:0];
            end
        end

        exp_x_d      = exp_x_q;
        exp_y_d      = exp_y_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_colour_d = out_colour_q;
        out_sof_d    = out_sof_q;
        out_eol_d    = out_eol_q;
        out_last_d   = out_last_q;
        frame_done_d = out_valid_q && out_ready && out_eol_q && out_last_q;
        // Every channel full with nothing matching can never make progress.
        stall_err_d  = stall_err_q || ((&full) && !(|match));

        if (pop_en) begin
            out_valid_d  = 1'b1;
            out_colour_d = sel_col;
            out_sof_d    = (exp_x_q == '0) && (exp_y_q == '0);
            out_eol_d    = (exp_x_q == X_LAST);
            out_last_d   = (exp_y_q == Y_LAST);
            if (exp_x_q == X_LAST) begin
                exp_x_d = '0;
                exp_y_d = (exp_y_q == Y_LAST) ? '0 : exp_y_q + 1'b1;
            end else begin
                exp_x_d = exp_x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_x_q      <= '0;
            exp_y_q      <= '0;
            out_valid_q  <= 1'b0;
            out_colour_q <= '0;
            out_sof_q    <= 1'b0;
            out_eol_q    <= 1'b0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            stall_err_q  <= 1'b0;
        end else begin
            exp_x_q      <= exp_x_d;
            exp_y_q      <= exp_y_d;
            out_valid_q  <= out_valid_d;
            out_colour_q <= out_colour_d;
            out_sof_q    <= out_sof_d;
            out_eol_q    <= out_eol_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_colour = out_colour_q;
    assign out_sof    = out_sof_q;
    assign out_eol    = out_eol_q;
    assign frame_done = frame_done_q;
    assign stall_err  = stall_err_q;

endmodule

// File: tb/tb_pixel_reorder_merge.sv
// Directed bench for pixel_reorder_merge with a 2-channel, 4-deep, 4x2 frame.
module tb_pixel_reorder_merge;

    localparam int NCH = 2;
    localparam int DEP = 4;
    localparam int CW  = 11;
    localparam int RW  = 24;
    localparam int XS  = 4;
    localparam int YS  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*CW-1:0] in_x;
    logic [NCH*CW-1:0] in_y;
    logic [NCH*RW-1:0] in_colour;
    logic [NCH-1:0]    ch_full;
    logic              out_valid;
    logic              out_ready;
    logic [RW-1:0]     out_colour;
    logic              out_sof;
    logic              out_eol;
    logic              frame_done;
    logic              stall_err;

    int          n_vec = 0;
    int          n_err = 0;
    bit          log_en = 1'b0;
    logic [31:0] got [$];
    logic [31:0] exp_seq [7] = '{32'h51, 32'h41, 32'h42, 32'h43, 32'h52, 32'h53, 32'h44};

    pixel_reorder_merge #(
        .NUM_CH  (NCH),
        .DEPTH   (DEP),
        .COORD_W (CW),
        .RGB_W   (RW),
        .X_SIZE  (XS),
        .Y_SIZE  (YS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .ch_full    (ch_full),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_colour (out_colour),
        .out_sof    (out_sof),
        .out_eol    (out_eol),
        .frame_done (frame_done),
        .stall_err  (stall_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (log_en && out_valid && out_ready) got.push_back(32'(out_colour));
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    task automatic set_ch(input int ch, input int x, input int y, input int col);
        in_valid[ch]           = 1'b1;
        in_x[ch*CW +: CW]      = CW'(x);
        in_y[ch*CW +: CW]      = CW'(y);
        in_colour[ch*RW +: RW] = RW'(col);
    endtask

    task automatic push1(input int ch, input int x, input int y, input int col);
        idle();
        set_ch(ch, x, y, col);
        tick();
        idle();
    endtask

    task automatic push2(input int x0, input int y0, input int c0,
                         input int x1, input int y1, input int c1);
        idle();
        set_ch(0, x0, y0, c0);
        set_ch(1, x1, y1, c1);
        tick();
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = '0;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
        out_ready = 1'b1;

        // Reset values
        do_reset();
        check_eq("rst_in_ready", 32'(in_ready), 32'h3);
        check_eq("rst_ch_full", 32'(ch_full), 32'h0);
        check_eq("rst_out_valid", 32'(out_valid), 32'h0);
        check_eq("rst_out_colour", 32'(out_colour), 32'h0);
        check_eq("rst_sof_eol", 32'({out_sof, out_eol}), 32'h0);
        check_eq("rst_frame_done", 32'(frame_done), 32'h0);
        check_eq("rst_stall_err", 32'(stall_err), 32'h0);

        // In-order frame on channel 0, colours 1..8
        for (int i = 0; i < 8; i++) begin
            idle();
            set_ch(0, i % XS, i / XS, i + 1);
            tick();
            if (i >= 1) begin
                check_eq("inord_valid", 32'(out_valid), 32'h1);
                check_eq("inord_colour", 32'(out_colour), 32'(i));
                check_eq("inord_sof", 32'(out_sof), 32'((i - 1) == 0));
                check_eq("inord_eol", 32'(out_eol), 32'(((i - 1) % XS) == XS - 1));
                check_eq("inord_fdone_low", 32'(frame_done), 32'h0);
            end
        end
        idle();
        tick();
        check_eq("inord_last_colour", 32'(out_colour), 32'h8);
        check_eq("inord_last_eol", 32'(out_eol), 32'h1);
        check_eq("inord_fdone_early", 32'(frame_done), 32'h0);
        tick();
        check_eq("inord_fdone_pulse", 32'(frame_done), 32'h1);
        check_eq("inord_drained", 32'(out_valid), 32'h0);
        tick();
        check_eq("inord_fdone_clear", 32'(frame_done), 32'h0);

        // Out of order across channels: (1,0) on ch1 before (0,0) on ch0
        push1(1, 1, 0, 'hB);
        check_eq("ooo_wait1", 32'(out_valid), 32'h0);
        push1(0, 0, 0, 'hA);
        check_eq("ooo_wait2", 32'(out_valid), 32'h0);
        tick();
        check_eq("ooo_first", 32'(out_colour), 32'hA);
        check_eq("ooo_first_sof", 32'(out_sof), 32'h1);
        tick();
        check_eq("ooo_second", 32'(out_colour), 32'hB);
        check_eq("ooo_second_valid", 32'(out_valid), 32'h1);
        tick();
        check_eq("ooo_drained", 32'(out_valid), 32'h0);

        // Backpressure: raster now expects (2,0)
        out_ready = 1'b0;
        push1(0, 2, 0, 'h21);
        push1(0, 3, 0, 'h22);
        check_eq("bp_loaded", 32'(out_colour), 32'h21);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_hold_valid", 32'(out_valid), 32'h1);
            check_eq("bp_hold_colour", 32'(out_colour), 32'h21);
            check_eq("bp_hold_marks", 32'({out_sof, out_eol}), 32'h0);
        end
        out_ready = 1'b1;
        tick();
        check_eq("bp_release_colour", 32'(out_colour), 32'h22);
        check_eq("bp_release_eol", 32'(out_eol), 32'h1);
        tick();
        check_eq("bp_release_drained", 32'(out_valid), 32'h0);

        // Full channel, dropped push, push during pop; raster expects (0,1)
        got.delete();
        log_en = 1'b1;
        push1(0, 1, 1, 'h41);
        push1(0, 2, 1, 'h42);
        push1(0, 3, 1, 'h43);
        push1(0, 2, 0, 'h44);
        check_eq("full_ch_full", 32'(ch_full), 32'h1);
        check_eq("full_in_ready", 32'(in_ready), 32'h2);
        push1(0, 3, 0, 'h45);
        check_eq("full_still_full", 32'(ch_full), 32'h1);
        check_eq("full_no_output", 32'(out_valid), 32'h0);
        push1(1, 0, 1, 'h51);
        push1(1, 0, 0, 'h52);
        push1(1, 1, 0, 'h53);
        check_eq("full_released", 32'(ch_full), 32'h0);
        for (int i = 0; i < 12; i++) tick();
        log_en = 1'b0;
        check_eq("full_out_count", 32'(got.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            check_eq("full_out_seq", (i < got.size()) ? got[i] : 32'hFFFF_FFFF, exp_seq[i]);
        end
        check_eq("full_stall_clear", 32'(stall_err), 32'h0);

        // Stall: both channels full, heads (2,1)/(3,1), raster at (0,0)
        do_reset();
        for (int i = 0; i < 3; i++) push2(2, 1, 'h60 + i, 3, 1, 'h70 + i);
        check_eq("stall_not_yet", 32'(stall_err), 32'h0);
        push2(2, 1, 'h63, 3, 1, 'h73);
        check_eq("stall_both_full", 32'(ch_full), 32'h3);
        tick();
        check_eq("stall_set", 32'(stall_err), 32'h1);
        for (int i = 0; i < 3; i++) tick();
        check_eq("stall_sticky", 32'(stall_err), 32'h1);
        do_reset();
        check_eq("stall_reset", 32'(stall_err), 32'h0);
        check_eq("stall_reset_ready", 32'(in_ready), 32'h3);

        // Mid-frame reset after three pixels
        push2(0, 0, 'h1, 2, 1, 'h81);
        push2(1, 0, 'h2, 2, 1, 'h82);
        push2(2, 0, 'h3, 2, 1, 'h83);
        push1(1, 2, 1, 'h84);
        check_eq("mid_third_pixel", 32'(out_colour), 32'h3);
        check_eq("mid_pre_ready", 32'(in_ready), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
        check_eq("mid_rst_ready", 32'(in_ready), 32'h3);
        check_eq("mid_rst_full", 32'(ch_full), 32'h0);
        tick();
        push1(0, 0, 0, 'h77);
        tick();
        check_eq("mid_restart_valid", 32'(out_valid), 32'h1);
        check_eq("mid_restart_colour", 32'(out_colour), 32'h77);
        check_eq("mid_restart_sof", 32'(out_sof), 32'h1);
        tick();
        check_eq("mid_restart_drained", 32'(out_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pixel_reorder_merge.md
# pixel_reorder_merge

Multi-channel pixel reorder buffer between the NUM_CH parallel colour engines and the video stream output. Each engine finishes pixels out of raster order and pushes (x, y, colour) into its own circular FIFO. A raster counter tracks the next expected coordinate; whichever channel head matches it is popped and emitted on a valid/ready stream with start-of-frame and end-of-line markers. Per-channel full flags go back to the distributor.

## Interface
- NUM_CH, 4, engine channels (≥1)
- DEPTH, 8, entries per channel FIFO (power of 2, ≥2)
- COORD_W, 11, coordinate width
- RGB_W, 24, colour width
- X_SIZE, 640, pixels per line
- Y_SIZE, 480, lines per frame
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  NUM_CH  per-channel push request
- in_ready  out  NUM_CH  channel can accept (count < DEPTH)
- in_x  in  NUM_CH×COORD_W  packed x per channel
- in_y  in  NUM_CH×COORD_W  packed y per channel
- in_colour  in  NUM_CH×RGB_W  packed colour per channel
- ch_full  out  NUM_CH  registered, count == DEPTH (to distributor)
- out_valid  out  1  output pixel valid
- out_ready  in  1  sink accepts
- out_colour  out  RGB_W  pixel colour
- out_sof  out  1  pixel is (0,0)
- out_eol  out  1  pixel has x == X_SIZE-1
- frame_done  out  1  one-cycle pulse when last pixel of frame accepted
- stall_err  out  1  sticky: every channel full and no head matches expected coordinate

## Operation
- Per channel: circular buffer, wr_ptr/rd_ptr of log2(DEPTH) bits wrapping naturally, count of log2(DEPTH)+1 bits.
- Push on channel c when in_valid[c] && in_ready[c]. in_ready[c] depends only on count, never on pop. A push arriving at full is dropped; the upstream engine must not push at full.
- Raster counter (exp_x, exp_y), reset (0,0). A channel matches when it is non-empty and its head equals (exp_x, exp_y).
- Pop enable: any match && (!out_valid || out_ready). The lowest-index matching channel wins. Other matching heads stay in place and are compared against later coordinates. Duplicates are an upstream error and are not detected here.
- On pop: the output register loads the head colour, out_sof = (exp_x==0 && exp_y==0), and out_eol = (exp_x==X_SIZE-1).
- Raster advance on pop: exp_x++. At X_SIZE-1, exp_x←0 and exp_y++. At (X_SIZE-1, Y_SIZE-1), wrap to (0,0).
- Simultaneous push and pop on one channel: both occur and count is unchanged. Pushing into a channel at count==DEPTH is refused even if it pops the same cycle.
- Output handshake: out_valid clears on out_ready unless a new pop loads the register in the same cycle. While out_valid && !out_ready, out_colour, out_sof and out_eol hold stable.
- frame_done pulses the cycle after acceptance of the pixel whose out_eol=1 and y==Y_SIZE-1. The y value is carried in an internal flag.
- stall_err sets when all ch_full=1 and there is no match. It clears only on reset.
- Reset (including mid-frame): all counts and pointers 0, raster (0,0), buffered pixels discarded.
- Reset values: in_ready all 1 one cycle after reset deasserts; ch_full=0, out_valid=0, out_colour=0, out_sof=0, out_eol=0, frame_done=0, stall_err=0.

## Timing
- Compare is combinational on registered heads. Pop and output load happen in the same edge.
- Latency: a push in cycle N is visible as head at N+1, so the earliest out_valid is N+2 if the pushed pixel is the expected coordinate.
- Throughput is one pixel per cycle with out_ready held high and the expected pixel present.
- ch_full and in_ready reflect count after the edge (registered count).

## Structure
- Package pixel_pkg: COORD_W, RGB_W and frame-size defaults, plus typedef pixel_t {x, y, colour}, shared with engines and distributor.
- Sub-module coord_fifo: one channel's circular buffer (push/pop, head, count, full, empty), instantiated NUM_CH times via generate.
- Top: match vector, fixed-priority select, raster counter, output register, error flag.

## Test plan
Bench parameters: NUM_CH=2, DEPTH=4, X_SIZE=4, Y_SIZE=2.
- In-order single channel: ch0 pushes (0,0)..(3,1), colours 1..8, out_ready=1 → colours 1..8 on consecutive cycles; sof on the first, eol on the 4th and 8th, frame_done after the 8th.
- Out-of-order across channels: ch1 pushes (1,0) c=0xB, then ch0 pushes (0,0) c=0xA → output 0xA then 0xB; the ch1 head holds until (0,0) is emitted.
- Backpressure: out_ready=0 for 5 cycles with a pixel valid → out_colour/sof/eol stable, no raster advance; one pixel emitted per cycle after release.
- Full and simultaneous: fill ch0 with 4 pixels → ch_full[0]=1, in_ready[0]=0, and a 5th push is dropped. Push ch1 while ch1 pops → count unchanged.
- Stall error: both channels full with heads (2,1),(3,1) while expecting (0,0) → stall_err=1 and stays set; reset clears it.
- Mid-frame reset after 3 pixels → out_valid=0, counts 0; the next frame restarts at (0,0) with sof=1.
